// File: rtl/jtlabrun_pkg.sv
// jtlabrun_pkg: shared ROM arbiter states and default ROM geometry
package jtlabrun_pkg;
    localparam int ROM_AW = 18;
    localparam int ROM_DW = 16;
    typedef enum logic [1:0] {IDLE, WAIT_SCR, WAIT_OBJ, SETTLE} arb_state_t;
endpackage

// File: rtl/jtlabrun_romarb_cache.sv
// jtlabrun_romarb_cache: one-word tag/data cache for a single ROM requester
module jtlabrun_romarb_cache import jtlabrun_pkg::*; #(
    parameter int AW = ROM_AW,
    parameter int DW = ROM_DW
) (
    input  logic          clk,
    input  logic          rstn,
    input  logic          cs,
    input  logic [AW-1:0] addr,
    input  logic          we,
    input  logic [AW-1:0] wr_addr,
    input  logic [DW-1:0] wr_data,
    output logic [DW-1:0] data,
    output logic          ok
);
    logic          valid;
    logic [AW-1:0] tag;
    always_ff @(posedge clk) begin
        if (!rstn) begin
            valid <= 1'b0;
            tag   <= '0;
            data  <= '0;
        end else if (we) begin
            valid <= 1'b1;
            tag   <= wr_addr;
            data  <= wr_data;
        end
    end
    assign ok = cs && valid && addr == tag;
endmodule

// File: rtl/jtlabrun_romarb.sv
// jtlabrun_romarb: shares one SDRAM slot between tilemap and object requesters
module jtlabrun_romarb import jtlabrun_pkg::*; #(
    parameter int AW      = ROM_AW,
    parameter int DW      = ROM_DW,
    parameter int OBJ_PRI = 0
) (
    input  logic          clk,
    input  logic          rstn,
    input  logic          scr_cs,
    input  logic [AW-1:0] scr_addr,
    output logic [DW-1:0] scr_data,
    output logic          scr_ok,
    input  logic          obj_cs,
    input  logic [AW-1:0] obj_addr,
    output logic [DW-1:0] obj_data,
    output logic          obj_ok,
    output logic          rom_cs,
    output logic [AW-1:0] rom_addr,
    input  logic [DW-1:0] rom_data,
    input  logic          rom_ok,
    output logic          rom_obj_sel
);
    arb_state_t    state, state_nx;
    logic          cs_nx, sel_nx, last_obj, last_nx, first, first_nx;
    logic          we_scr, we_obj, scr_pend, obj_pend, gnt_obj, abort;
    logic [AW-1:0] addr_nx;

    jtlabrun_romarb_cache #(.AW(AW), .DW(DW)) u_scr (
        .clk(clk), .rstn(rstn), .cs(scr_cs), .addr(scr_addr), .we(we_scr),
        .wr_addr(rom_addr), .wr_data(rom_data), .data(scr_data), .ok(scr_ok)
    );
    jtlabrun_romarb_cache #(.AW(AW), .DW(DW)) u_obj (
        .clk(clk), .rstn(rstn), .cs(obj_cs), .addr(obj_addr), .we(we_obj),
        .wr_addr(rom_addr), .wr_data(rom_data), .data(obj_data), .ok(obj_ok)
    );

    assign scr_pend = scr_cs && !scr_ok;
    assign obj_pend = obj_cs && !obj_ok;
    assign gnt_obj  = obj_pend && (!scr_pend || OBJ_PRI != 0 || !last_obj);
    // the granted requester walking away or moving invalidates the access in flight
    assign abort    = rom_obj_sel ? (!obj_cs || obj_addr != rom_addr)
                                  : (!scr_cs || scr_addr != rom_addr);

    always_comb begin
        state_nx = state;
        cs_nx    = rom_cs;
        addr_nx  = rom_addr;
        sel_nx   = rom_obj_sel;
        last_nx  = last_obj;
        first_nx = 1'b0;
        we_scr   = 1'b0;
        we_obj   = 1'b0;
        case (state)
            IDLE: if (scr_pend || obj_pend) begin
                state_nx = gnt_obj ? WAIT_OBJ : WAIT_SCR;
                cs_nx    = 1'b1;
                addr_nx  = gnt_obj ? obj_addr : scr_addr;
                sel_nx   = gnt_obj;
                first_nx = 1'b1;
            end
            WAIT_SCR, WAIT_OBJ: if (abort) begin
                state_nx = IDLE;
                cs_nx    = 1'b0;
            end else if (!first && rom_ok) begin
                state_nx = SETTLE;
                cs_nx    = 1'b0;
                we_scr   = state == WAIT_SCR;
                we_obj   = state == WAIT_OBJ;
            end
            SETTLE: begin
                state_nx = IDLE;
                last_nx  = rom_obj_sel;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state       <= IDLE;
            rom_cs      <= 1'b0;
            rom_addr    <= '0;
            rom_obj_sel <= 1'b0;
            last_obj    <= 1'b0;
            first       <= 1'b0;
        end else begin
            state       <= state_nx;
            rom_cs      <= cs_nx;
            rom_addr    <= addr_nx;
            rom_obj_sel <= sel_nx;
            last_obj    <= last_nx;
            first       <= first_nx;
        end
    end
endmodule

// File: tb/tb_jtlabrun_romarb.sv
// tb_jtlabrun_romarb: directed vector table, scenario sequence and randomized SDRAM traffic
module tb_jtlabrun_romarb;
    localparam int AW = 18;
    localparam int DW = 16;

    logic          clk = 1'b0, rstn = 1'b0;
    logic          scr_cs = 1'b0, obj_cs = 1'b0, rom_ok = 1'b0;
    logic [AW-1:0] scr_addr = '0, obj_addr = '0;
    logic [DW-1:0] rom_data = '0;
    logic [DW-1:0] scr_data, obj_data;
    logic          scr_ok, obj_ok, rom_cs, rom_obj_sel;
    logic [AW-1:0] rom_addr;
    int            vecs = 0, errs = 0;

    always #5 clk = ~clk;

    jtlabrun_romarb #(.AW(AW), .DW(DW), .OBJ_PRI(0)) dut (
        .clk(clk), .rstn(rstn),
        .scr_cs(scr_cs), .scr_addr(scr_addr), .scr_data(scr_data), .scr_ok(scr_ok),
        .obj_cs(obj_cs), .obj_addr(obj_addr), .obj_data(obj_data), .obj_ok(obj_ok),
        .rom_cs(rom_cs), .rom_addr(rom_addr), .rom_data(rom_data), .rom_ok(rom_ok),
        .rom_obj_sel(rom_obj_sel)
    );

    typedef struct {
        logic rstn, scs; logic [AW-1:0] sa; logic ocs; logic [AW-1:0] oa;
        logic rok; logic [DW-1:0] rd;
        logic e_cs; logic [AW-1:0] e_addr; logic e_sel, e_sok; logic [DW-1:0] e_sd;
        logic e_ook; logic [DW-1:0] e_od;
    } vec_t;
    vec_t tbl[21];

    function automatic vec_t mk(logic r, logic sc, logic [AW-1:0] sa, logic oc, logic [AW-1:0] oa,
                                logic rk, logic [DW-1:0] rd, logic ec, logic [AW-1:0] ea, logic es,
                                logic esk, logic [DW-1:0] esd, logic eok, logic [DW-1:0] eod);
        vec_t v;
        v.rstn = r; v.scs = sc; v.sa = sa; v.ocs = oc; v.oa = oa; v.rok = rk; v.rd = rd;
        v.e_cs = ec; v.e_addr = ea; v.e_sel = es; v.e_sok = esk; v.e_sd = esd; v.e_ook = eok; v.e_od = eod;
        return v;
    endfunction

    // expected ROM contents for the random phase: any deterministic scramble of the address
    function automatic logic [DW-1:0] mem(logic [AW-1:0] a);
        logic [31:0] t;
        t = {14'd0, a} * 32'h9E37;
        return t[15:0] ^ 16'h5A5A;
    endfunction

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        vecs++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s got=%h expected=%h", name, got, exp);
        end
    endtask

    function automatic logic [63:0] outs();
        return {10'd0, rom_cs, rom_addr, rom_obj_sel, scr_ok, scr_data, obj_ok, obj_data};
    endfunction

    logic          rcs[2], pok[2], prev_cs, prev_sel, prev_scs, prev_ocs, prev_sok, prev_ook, sd_busy;
    logic [AW-1:0] raddr[2], prev_addr, prev_sa, prev_oa, sd_addr, exp_a;
    int            age[2], sd_cnt;

    initial begin
        //                  rstn scs sa     ocs oa     rok rd        cs addr   sel sok sd        ook od
        tbl[0]  = mk(1, 1, 'h100, 1, 'h080, 0, 'h0000,  0, 'h000, 0, 0, 'h0000, 0, 'h0000);
        tbl[1]  = mk(1, 1, 'h100, 1, 'h080, 0, 'h0000,  1, 'h080, 1, 0, 'h0000, 0, 'h0000);
        tbl[2]  = mk(1, 1, 'h100, 1, 'h080, 1, 'h1111,  1, 'h080, 1, 0, 'h0000, 0, 'h0000);
        tbl[3]  = mk(1, 1, 'h100, 1, 'h080, 0, 'h0000,  0, 'h080, 1, 0, 'h0000, 1, 'h1111);
        tbl[4]  = mk(1, 1, 'h100, 1, 'h080, 1, 'hDEAD,  0, 'h080, 1, 0, 'h0000, 1, 'h1111);
        tbl[5]  = mk(1, 1, 'h100, 1, 'h080, 1, 'hDEAD,  1, 'h100, 0, 0, 'h0000, 1, 'h1111);
        tbl[6]  = mk(1, 1, 'h100, 1, 'h080, 1, 'hA55A,  1, 'h100, 0, 0, 'h0000, 1, 'h1111);
        tbl[7]  = mk(1, 1, 'h100, 1, 'h080, 0, 'h0000,  0, 'h100, 0, 1, 'hA55A, 1, 'h1111);
        tbl[8]  = mk(1, 1, 'h100, 1, 'h080, 0, 'h0000,  0, 'h100, 0, 1, 'hA55A, 1, 'h1111);
        tbl[9]  = mk(1, 1, 'h100, 1, 'h200, 0, 'h0000,  0, 'h100, 0, 1, 'hA55A, 0, 'h1111);
        tbl[10] = mk(1, 1, 'h100, 1, 'h200, 0, 'h0000,  1, 'h200, 1, 1, 'hA55A, 0, 'h1111);
        tbl[11] = mk(1, 1, 'h100, 1, 'h201, 0, 'h0000,  1, 'h200, 1, 1, 'hA55A, 0, 'h1111);
        tbl[12] = mk(1, 1, 'h100, 1, 'h080, 1, 'hBEEF,  0, 'h200, 1, 1, 'hA55A, 1, 'h1111);
        tbl[13] = mk(1, 1, 'h100, 1, 'h201, 0, 'h0000,  0, 'h200, 1, 1, 'hA55A, 0, 'h1111);
        tbl[14] = mk(1, 1, 'h100, 1, 'h201, 0, 'h0000,  1, 'h201, 1, 1, 'hA55A, 0, 'h1111);
        tbl[15] = mk(0, 1, 'h100, 1, 'h201, 1, 'h7777,  1, 'h201, 1, 1, 'hA55A, 0, 'h1111);
        tbl[16] = mk(1, 0, 'h100, 0, 'h201, 0, 'h0000,  0, 'h000, 0, 0, 'h0000, 0, 'h0000);
        tbl[17] = mk(1, 1, 'h100, 0, 'h201, 0, 'h0000,  0, 'h000, 0, 0, 'h0000, 0, 'h0000);
        tbl[18] = mk(1, 1, 'h100, 0, 'h201, 0, 'h0000,  1, 'h100, 0, 0, 'h0000, 0, 'h0000);
        tbl[19] = mk(1, 0, 'h100, 0, 'h201, 0, 'h0000,  1, 'h100, 0, 0, 'h0000, 0, 'h0000);
        tbl[20] = mk(1, 0, 'h100, 0, 'h201, 0, 'h0000,  0, 'h100, 0, 0, 'h0000, 0, 'h0000);

        repeat (2) @(posedge clk);
        #1 chk("reset_state", outs(), 64'd0);
        for (int i = 0; i < 21; i++) begin
            @(posedge clk); #1;
            rstn = tbl[i].rstn; scr_cs = tbl[i].scs; scr_addr = tbl[i].sa;
            obj_cs = tbl[i].ocs; obj_addr = tbl[i].oa; rom_ok = tbl[i].rok; rom_data = tbl[i].rd;
            #1 chk($sformatf("row%0d", i), outs(),
                   {10'd0, tbl[i].e_cs, tbl[i].e_addr, tbl[i].e_sel, tbl[i].e_sok, tbl[i].e_sd, tbl[i].e_ook, tbl[i].e_od});
        end

        // single miss answered on the third WAIT cycle
        @(posedge clk); #1 rstn = 1'b0; scr_cs = 1'b0; obj_cs = 1'b0; rom_ok = 1'b0;
        @(posedge clk); #1 rstn = 1'b1; scr_cs = 1'b1; scr_addr = 'h100;
        #1 chk("s1_idle", {rom_cs, scr_ok}, 2'b00);
        @(posedge clk); #2 chk("s1_wait1", {rom_cs, rom_addr, rom_obj_sel}, {1'b1, 18'h00100, 1'b0});
        @(posedge clk); #2 chk("s1_wait2", {rom_cs, scr_ok}, 2'b10);
        @(posedge clk); #1 rom_ok = 1'b1; rom_data = 'hA55A;
        #1 chk("s1_wait3", {rom_cs, scr_ok}, 2'b10);
        @(posedge clk); #1 rom_ok = 1'b0; rom_data = 'h0;
        #1 chk("s1_settle", {rom_cs, scr_ok, scr_data}, {1'b0, 1'b1, 16'hA55A});
        @(posedge clk); #2 chk("s1_hit", {rom_cs, scr_ok, scr_data}, {1'b0, 1'b1, 16'hA55A});

        // randomized traffic against a latency-variable SDRAM with garbage rom_ok outside valid beats
        @(posedge clk); #1 rstn = 1'b0; scr_cs = 1'b0; obj_cs = 1'b0;
        @(posedge clk); #1 rstn = 1'b1;
        rcs = '{1'b0, 1'b0}; pok = '{1'b0, 1'b0}; raddr = '{'h100, 'h200}; age = '{0, 0};
        prev_cs = 1'b0; prev_sel = 1'b0; prev_addr = '0; prev_scs = 1'b0; prev_ocs = 1'b0;
        prev_sok = 1'b0; prev_ook = 1'b0; prev_sa = '0; prev_oa = '0; sd_busy = 1'b0; sd_addr = '0; sd_cnt = 0;
        for (int c = 0; c < 4000; c++) begin
            @(posedge clk); #1;
            if (rom_cs && sd_busy && rom_addr == sd_addr) begin
                if (sd_cnt == 0) begin
                    rom_ok = 1'b1; rom_data = mem(sd_addr);
                end else begin
                    sd_cnt--; rom_ok = 1'b0; rom_data = DW'($urandom);
                end
            end else begin
                sd_busy = rom_cs; sd_addr = rom_addr; sd_cnt = $urandom_range(0, 3);
                rom_ok = 1'($urandom); rom_data = DW'($urandom);
            end
            for (int r = 0; r < 2; r++) begin
                if (!rcs[r]) begin
                    if ($urandom_range(0, 3) != 0) begin
                        rcs[r] = 1'b1; raddr[r] = (r == 0 ? 18'h100 : 18'h200) + AW'($urandom_range(0, 5)); age[r] = 0;
                    end
                end else if (pok[r]) begin
                    case ($urandom_range(0, 3))
                        0: rcs[r] = 1'b0;
                        1, 2: begin raddr[r] = (r == 0 ? 18'h100 : 18'h200) + AW'($urandom_range(0, 5)); age[r] = 0; end
                        default: ;
                    endcase
                end else if ($urandom_range(0, 31) == 0) begin
                    raddr[r] = (r == 0 ? 18'h100 : 18'h200) + AW'($urandom_range(0, 5)); age[r] = 0;
                end
            end
            scr_cs = rcs[0]; scr_addr = raddr[0]; obj_cs = rcs[1]; obj_addr = raddr[1];
            #1;
            if (scr_ok) chk("rnd_scr_data", {scr_cs, scr_data}, {1'b1, mem(scr_addr)});
            if (obj_ok) chk("rnd_obj_data", {obj_cs, obj_data}, {1'b1, mem(obj_addr)});
            if (rom_cs && prev_cs) chk("rnd_rom_stable", {rom_addr, rom_obj_sel}, {prev_addr, prev_sel});
            if (rom_cs && !prev_cs) begin
                exp_a = rom_obj_sel ? prev_oa : prev_sa;
                chk("rnd_grant", {rom_addr, rom_obj_sel ? (prev_ocs && !prev_ook) : (prev_scs && !prev_sok)}, {exp_a, 1'b1});
            end
            age[0] = (scr_cs && !scr_ok) ? age[0] + 1 : 0;
            age[1] = (obj_cs && !obj_ok) ? age[1] + 1 : 0;
            chk("rnd_scr_live", age[0] > 60, 1'b0);
            chk("rnd_obj_live", age[1] > 60, 1'b0);
            if (age[0] > 60) age[0] = 0;
            if (age[1] > 60) age[1] = 0;
            pok[0] = scr_ok; pok[1] = obj_ok;
            prev_cs = rom_cs; prev_sel = rom_obj_sel; prev_addr = rom_addr;
            prev_scs = scr_cs; prev_ocs = obj_cs; prev_sok = scr_ok; prev_ook = obj_ok;
            prev_sa = scr_addr; prev_oa = obj_addr;
        end
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end
endmodule
